digit_grid_renderer: RTL and testbench

//  Parametrised, pipelined successor to the combinational digit screen for the 24-game VGA path.

---
 rtl/digit_grid_renderer_if.sv | 23 ++
 rtl/digit_grid_renderer.sv | 229 ++++++++++++++++++++++
 tb/tb_digit_grid_renderer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_grid_renderer_if.sv
// Pixel-stream bus between the VGA timing generator and the digit grid renderer.
// The master side drives the pixel position, display-enable and frame pulse.
// The slave side returns the 8-bit RGB and the matching delayed display-enable.
interface digit_grid_renderer_if;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       de;
    logic       frame_start;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;
    logic       de_out;

    modport master (
        output sx, sy, de, frame_start,
        input  vga_r, vga_g, vga_b, de_out
    );

    modport slave (
        input  sx, sy, de, frame_start,
        output vga_r, vga_g, vga_b, de_out
    );
endinterface

// File: rtl/digit_grid_renderer.sv
// Three-stage pixel renderer for a ROWS x COLS grid of 7-segment digit cells
// plus one W/L status cell, with group highlight and a frame-counted blink.
// All display inputs are shadowed on frame_start so a frame never tears.
module digit_grid_renderer #(
    parameter int unsigned COLS   = 6,
    parameter int unsigned ROWS   = 2,
    parameter int unsigned CELL_W = 80,
    parameter int unsigned CELL_H = 140,
    parameter int unsigned GAP_X  = 20,
    parameter int unsigned GAP_Y  = 40,
    parameter int unsigned ORG_X  = 20,
    parameter int unsigned ORG_Y  = 20,
    parameter int unsigned GROUP  = 3,
    parameter int unsigned STAT_X = 120,
    parameter int unsigned STAT_Y = 340,
    parameter int unsigned BLINK  = 30,
    localparam int unsigned NCELLS = ROWS * COLS,
    localparam int unsigned NGRP   = (NCELLS + GROUP - 1) / GROUP,
    localparam int unsigned GW     = (NGRP > 1) ? $clog2(NGRP) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    digit_grid_renderer_if.slave  bus,
    input  logic [4*NCELLS-1:0]   numbers_concat,
    input  logic [GW:0]           sel_a,
    input  logic [GW:0]           sel_b,
    input  logic                  win,
    input  logic                  lose
);

    localparam int unsigned T   = CELL_W / 8;
    localparam int unsigned HT  = T / 2;
    localparam int unsigned H2  = CELL_H / 2;
    localparam int unsigned PX  = CELL_W + GAP_X;
    localparam int unsigned PY  = CELL_H + GAP_Y;

    localparam logic [7:0] COL_WHITE = 8'hFF;
    localparam logic [7:0] COL_RED   = 8'hE0;
    localparam logic [7:0] COL_DIM   = 8'h80;
    localparam logic [7:0] COL_GREEN = 8'h1C;
    localparam logic [3:0] GLYPH_L   = 4'd10;
    localparam logic [3:0] GLYPH_W   = 4'd11;
    localparam logic [3:0] GLYPH_OFF = 4'd15;

    // Frame shadows
    logic [4*NCELLS-1:0] sh_num;
    logic [GW:0]         sh_sel_a;
    logic [GW:0]         sh_sel_b;
    logic                sh_win;
    logic                sh_lose;
    logic [31:0]         frame_cnt;
    logic                phase;

    // Stage registers
    logic [3:0] s1_glyph;
    logic [7:0] s1_colour;
    logic [9:0] s1_ox;
    logic [9:0] s1_oy;
    logic       s1_de;
    logic [7:0] s2_rgb;
    logic       s2_de;
    logic [7:0] rgb_q;
    logic       de_q;

    // Stage-1 combinational results
    logic [31:0]  px, py;
    logic         hit_col, hit_row, hit_stat, sel_hit;
    int unsigned  col_i, row_i, cell_i, grp_i;
    logic [9:0]   gx, gy;
    logic [3:0]   digit;
    logic [3:0]   n1_glyph;
    logic [7:0]   n1_colour;
    logic [9:0]   n1_ox, n1_oy;

    // Stage-2 combinational results
    logic [31:0] ox32, oy32;
    logic        hband;
    logic [6:0]  seg;
    logic [6:0]  mask;
    logic [7:0]  n2_rgb;

    // Capture display inputs and advance the blink counter on each frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_num    <= '1;
            sh_sel_a  <= '0;
            sh_sel_b  <= '0;
            sh_win    <= 1'b0;
            sh_lose   <= 1'b0;
            frame_cnt <= '0;
            phase     <= 1'b0;
        end else if (bus.frame_start) begin
            sh_num   <= numbers_concat;
            sh_sel_a <= sel_a;
            sh_sel_b <= sel_b;
            sh_win   <= win;
            sh_lose  <= lose;
            if (BLINK == 0) begin
                frame_cnt <= '0;
                phase     <= 1'b0;
            end else if (frame_cnt == 32'(BLINK - 1)) begin
                frame_cnt <= '0;
                phase     <= ~phase;
            end else begin
                frame_cnt <= frame_cnt + 32'd1;
            end
        end
    end

    // Locate the cell under the pixel and resolve its glyph and colour from the shadows
    always_comb begin
        px        = 32'(bus.sx);
        py        = 32'(bus.sy);
        hit_col   = 1'b0;
        hit_row   = 1'b0;
        col_i     = 0;
        row_i     = 0;
        gx        = '0;
        gy        = '0;
        digit     = GLYPH_OFF;
        n1_glyph  = GLYPH_OFF;
        n1_colour = '0;
        n1_ox     = '0;
        n1_oy     = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (px >= ORG_X + c * PX && px < ORG_X + c * PX + CELL_W) begin
                hit_col = 1'b1;
                col_i   = c;
                gx      = 10'(px - (ORG_X + c * PX));
            end
        end
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (py >= ORG_Y + r * PY && py < ORG_Y + r * PY + CELL_H) begin
                hit_row = 1'b1;
                row_i   = r;
                gy      = 10'(py - (ORG_Y + r * PY));
            end
        end
        cell_i = row_i * COLS + col_i;
        grp_i  = cell_i / GROUP;
        for (int unsigned c = 0; c < NCELLS; c++) begin
            if (cell_i == c) digit = sh_num[4*(NCELLS-1-c) +: 4];
        end
        // grp_i is always below NGRP, so an out-of-range index can never match
        sel_hit = (sh_sel_a[GW] && 32'(sh_sel_a[GW-1:0]) == grp_i) ||
                  (sh_sel_b[GW] && 32'(sh_sel_b[GW-1:0]) == grp_i);
        hit_stat = px >= STAT_X && px < STAT_X + CELL_W &&
                   py >= STAT_Y && py < STAT_Y + CELL_H;
        if (hit_stat) begin
            n1_glyph  = sh_win ? GLYPH_W : (sh_lose ? GLYPH_L : GLYPH_OFF);
            n1_colour = sh_win ? COL_GREEN : COL_RED;
            n1_ox     = 10'(px - STAT_X);
            n1_oy     = 10'(py - STAT_Y);
        end else if (hit_col && hit_row) begin
            n1_glyph  = digit;
            n1_colour = sel_hit ? (phase ? COL_DIM : COL_RED) : COL_WHITE;
            n1_ox     = gx;
            n1_oy     = gy;
        end
    end

    // Stage 1 register: cell attributes and in-cell offsets
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_glyph  <= GLYPH_OFF;
            s1_colour <= '0;
            s1_ox     <= '0;
            s1_oy     <= '0;
            s1_de     <= 1'b0;
        end else begin
            s1_glyph  <= n1_glyph;
            s1_colour <= n1_colour;
            s1_ox     <= n1_ox;
            s1_oy     <= n1_oy;
            s1_de     <= bus.de;
        end
    end

    // Segment hit test against the glyph's segment mask {a,b,c,d,e,f,g}
    always_comb begin
        ox32   = 32'(s1_ox);
        oy32   = 32'(s1_oy);
        hband  = ox32 >= T && ox32 < CELL_W - T;
        seg[6] = oy32 < T && hband;
        seg[5] = ox32 >= CELL_W - T && oy32 < H2;
        seg[4] = ox32 >= CELL_W - T && oy32 >= H2;
        seg[3] = oy32 >= CELL_H - T && hband;
        seg[2] = ox32 < T && oy32 >= H2;
        seg[1] = ox32 < T && oy32 < H2;
        seg[0] = (oy32 + HT > H2) && (oy32 < H2 + HT) && hband;
        case (s1_glyph)
            4'd0:    mask = 7'h7E;
            4'd1:    mask = 7'h30;
            4'd2:    mask = 7'h6D;
            4'd3:    mask = 7'h79;
            4'd4:    mask = 7'h33;
            4'd5:    mask = 7'h5B;
            4'd6:    mask = 7'h5F;
            4'd7:    mask = 7'h70;
            4'd8:    mask = 7'h7F;
            4'd9:    mask = 7'h7B;
            4'd10:   mask = 7'h0E;
            4'd11:   mask = 7'h3E;
            default: mask = 7'h00;
        endcase
        n2_rgb = (s1_de && |(seg & mask)) ? s1_colour : '0;
    end

    // Stage 2 and stage 3 registers: colour select, then the output pins
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_rgb <= '0;
            s2_de  <= 1'b0;
            rgb_q  <= '0;
            de_q   <= 1'b0;
        end else begin
            s2_rgb <= n2_rgb;
            s2_de  <= s1_de;
            rgb_q  <= s2_rgb;
            de_q   <= s2_de;
        end
    end

    assign bus.vga_r  = rgb_q[7:5];
    assign bus.vga_g  = rgb_q[4:2];
    assign bus.vga_b  = rgb_q[1:0];
    assign bus.de_out = de_q;

endmodule

// File: tb/tb_digit_grid_renderer.sv
// Directed bench for digit_grid_renderer: rendering, blink, status cell,
// tear-free shadowing, gaps/blanking, selection range and mid-frame reset.
module tb_digit_grid_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [47:0] numbers_concat = '0;
    logic [2:0]  sel_a = '0;
    logic [2:0]  sel_b = '0;
    logic [2:0]  sel_a2 = '0;
    logic [2:0]  sel_b2 = '0;
    logic        win = 1'b0;
    logic        lose = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          nfr = 0;
    logic [7:0]  rgb, rgb2;
    logic [7:0]  exp_sel;

    digit_grid_renderer_if bus ();
    digit_grid_renderer_if bus2 ();

    assign bus2.sx          = bus.sx;
    assign bus2.sy          = bus.sy;
    assign bus2.de          = bus.de;
    assign bus2.frame_start = bus.frame_start;
    assign rgb  = {bus.vga_r, bus.vga_g, bus.vga_b};
    assign rgb2 = {bus2.vga_r, bus2.vga_g, bus2.vga_b};

    always #5 clk = ~clk;

    digit_grid_renderer u_dut (
        .clk(clk), .rst(rst), .bus(bus), .numbers_concat(numbers_concat),
        .sel_a(sel_a), .sel_b(sel_b), .win(win), .lose(lose)
    );

    // Four cells per group: NGRP = 3, so group index 3 is out of range
    digit_grid_renderer #(.GROUP(4)) u_dut2 (
        .clk(clk), .rst(rst), .bus(bus2), .numbers_concat(numbers_concat),
        .sel_a(sel_a2), .sel_b(sel_b2), .win(win), .lose(lose)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.de = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nfr = 0;
    endtask

    task automatic pulse_fs();
        @(negedge clk);
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        nfr++;
    endtask

    task automatic show(input int x, input int y, input logic d);
        @(negedge clk);
        bus.sx = 10'(x);
        bus.sy = 10'(y);
        bus.de = d;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.sx = 10'd145; bus.sy = 10'd22; bus.de = 1'b1; bus.frame_start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL reset_rgb: got %h want 00", rgb); end
        checks++;
        if (bus.de_out !== 1'b0) begin errors++; $display("FAIL reset_de_out: got %b want 0", bus.de_out); end
        rst = 1'b0;
        nfr = 0;
        show(145, 22, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL reset_blank_digits: got %h want 00", rgb); end
    endtask

    task automatic test_render();
        do_reset();
        numbers_concat = 48'h123456789012;
        sel_a = '0; sel_b = '0; win = 1'b0; lose = 1'b0;
        pulse_fs();
        show(60, 22, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL render_cell0_no_a: got %h want 00", rgb); end
        show(145, 22, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL render_cell1_a: got %h want FF", rgb); end
        checks++;
        if (bus.de_out !== 1'b1) begin errors++; $display("FAIL render_de_out: got %b want 1", bus.de_out); end
        show(195, 122, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL render_cell1_no_c: got %h want 00", rgb); end
        show(495, 230, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL render_cell10_b: got %h want FF", rgb); end
        show(345, 202, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL render_cell9_a: got %h want FF", rgb); end
    endtask

    task automatic test_latency();
        show(105, 30, 1'b1);
        @(negedge clk);
        bus.sx = 10'd145; bus.sy = 10'd22;
        @(negedge clk);
        bus.sx = 10'd105; bus.sy = 10'd30;
        @(negedge clk);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL latency_early: got %h want 00", rgb); end
        @(negedge clk);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL latency_3clk: got %h want FF", rgb); end
        @(negedge clk);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL latency_after: got %h want 00", rgb); end
    endtask

    task automatic test_blink();
        do_reset();
        numbers_concat = 48'h123456789012;
        sel_a = 3'b100;
        pulse_fs();
        for (int k = 0; k < 3; k++) begin
            exp_sel = (((nfr / 30) % 2) == 1) ? 8'h80 : 8'hE0;
            show(145, 22, 1'b1);
            checks++;
            if (rgb !== exp_sel) begin errors++; $display("FAIL blink_sel_cell1 step %0d: got %h want %h", k, rgb, exp_sel); end
            show(245, 22, 1'b1);
            checks++;
            if (rgb !== exp_sel) begin errors++; $display("FAIL blink_sel_cell2 step %0d: got %h want %h", k, rgb, exp_sel); end
            show(395, 50, 1'b1);
            checks++;
            if (rgb !== 8'hFF) begin errors++; $display("FAIL blink_unsel_cell3 step %0d: got %h want FF", k, rgb); end
            while (nfr < 30 * (k + 1)) pulse_fs();
        end
        sel_a = '0;
    endtask

    task automatic test_status();
        do_reset();
        win = 1'b1; lose = 1'b1;
        pulse_fs();
        show(122, 410, 1'b1);
        checks++;
        if (rgb !== 8'h1C) begin errors++; $display("FAIL status_win_e: got %h want 1C", rgb); end
        show(197, 360, 1'b1);
        checks++;
        if (rgb !== 8'h1C) begin errors++; $display("FAIL status_win_b: got %h want 1C", rgb); end
        win = 1'b0; lose = 1'b1;
        pulse_fs();
        show(122, 410, 1'b1);
        checks++;
        if (rgb !== 8'hE0) begin errors++; $display("FAIL status_lose_e: got %h want E0", rgb); end
        show(197, 360, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL status_lose_b: got %h want 00", rgb); end
        win = 1'b0; lose = 1'b0;
        pulse_fs();
        show(122, 410, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL status_none: got %h want 00", rgb); end
    endtask

    task automatic test_no_tear();
        do_reset();
        numbers_concat = 48'h123456789012;
        sel_a = '0; sel_b = '0;
        pulse_fs();
        numbers_concat = 48'h888888888888;
        show(60, 22, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL tear_midframe: got %h want 00", rgb); end
        @(negedge clk);
        bus.frame_start = 1'b1;
        bus.sx = 10'd60; bus.sy = 10'd22; bus.de = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
        nfr++;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL tear_same_cycle: got %h want 00", rgb); end
        @(negedge clk);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL tear_next_cycle: got %h want FF", rgb); end
    endtask

    task automatic test_gap_de_sel();
        do_reset();
        numbers_concat = 48'h123456789012;
        sel_a = '0; sel_b = 3'b111; sel_a2 = '0; sel_b2 = 3'b111;
        pulse_fs();
        show(105, 30, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL gap_pixel: got %h want 00", rgb); end
        show(145, 22, 1'b0);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL de_low_rgb: got %h want 00", rgb); end
        checks++;
        if (bus.de_out !== 1'b0) begin errors++; $display("FAIL de_low_de_out: got %b want 0", bus.de_out); end
        show(345, 202, 1'b1);
        checks++;
        if (rgb !== 8'hE0) begin errors++; $display("FAIL sel_b_grp3_cell9: got %h want E0", rgb); end
        show(245, 202, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL sel_b_grp2_cell8: got %h want FF", rgb); end
        checks++;
        if (rgb2 !== 8'hFF) begin errors++; $display("FAIL range_cell8: got %h want FF", rgb2); end
        show(545, 202, 1'b1);
        checks++;
        if (rgb2 !== 8'hFF) begin errors++; $display("FAIL range_cell11: got %h want FF", rgb2); end
        show(445, 22, 1'b1);
        checks++;
        if (rgb2 !== 8'hFF) begin errors++; $display("FAIL range_cell4: got %h want FF", rgb2); end
        sel_b = '0; sel_b2 = '0;
    endtask

    task automatic test_rst_midframe();
        do_reset();
        numbers_concat = 48'h123456789012;
        win = 1'b1;
        pulse_fs();
        show(145, 22, 1'b1);
        checks++;
        if (rgb !== 8'hFF) begin errors++; $display("FAIL midrst_before: got %h want FF", rgb); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL midrst_next_edge: got %h want 00", rgb); end
        @(negedge clk);
        rst = 1'b0;
        nfr = 0;
        show(145, 22, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL midrst_blank_digit: got %h want 00", rgb); end
        checks++;
        if (bus.de_out !== 1'b1) begin errors++; $display("FAIL midrst_de_out: got %b want 1", bus.de_out); end
        show(122, 410, 1'b1);
        checks++;
        if (rgb !== 8'h00) begin errors++; $display("FAIL midrst_blank_status: got %h want 00", rgb); end
        win = 1'b0;
    endtask

    initial begin
        bus.sx = '0;
        bus.sy = '0;
        bus.de = 1'b0;
        bus.frame_start = 1'b0;
        test_reset();
        test_render();
        test_latency();
        test_blink();
        test_status();
        test_no_tear();
        test_gap_de_sel();
        test_rst_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
